// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM encoding,
// default bus widths and response codes.
package apb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB3 segment of the initiator.
// master: initiator view, slave: requester + responder view.
interface apb_master_if #(
   parameter int ADDR_W = apb_pkg::ADDR_W_DEF,
   parameter int DATA_W = apb_pkg::DATA_W_DEF
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states; expired_o once TIMEOUT is reached.
// Ports: clk_i, rst_i, clear_i, enable_i -> expired_o.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   if (TIMEOUT == 0) begin : g_off
      assign expired_o = 1'b0;
   end else begin : g_on
      localparam int W = $clog2(TIMEOUT + 1);

      logic [W-1:0] cnt_q;
      logic [W-1:0] cnt_d;

      assign expired_o = (cnt_q == W'(TIMEOUT));

      // saturate at TIMEOUT so the count never wraps
      always_comb begin
         cnt_d = cnt_q;
         if (clear_i) begin
            cnt_d = '0;
         end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: valid/ready command in, SETUP/ACCESS out,
// one-cycle rsp pulse back. Ports: pclk, preset, bus (master).
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic         pclk,
   input  logic         preset,
   apb_master_if.master bus
);

   state_e            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              cmd_ready;
   logic              tmr_clr;
   logic              tmr_en;
   logic              expired;
   logic              done;

   apb_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk_i    (pclk),
      .rst_i    (preset),
      .clear_i  (tmr_clr),
      .enable_i (tmr_en),
      .expired_o(expired)
   );

   // transfer ends on pready, or on timeout with pready still low
   assign done = (state_q == ST_ACCESS) &&
                 (bus.pready || expired);

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;
      cmd_ready   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = !preset;
            if (bus.cmd_valid) begin
               pwrite_d  = bus.cmd_write;
               paddr_d   = bus.cmd_addr;
               pwdata_d  = bus.cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               tmr_clr   = 1'b1;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            tmr_en = !bus.pready;
            if (bus.pready) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
               rsp_err_d   = bus.pslverr ? RSP_ERR : RSP_OK;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
            end else if (expired) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = RSP_ERR;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with an SRAM-like responder
// and a response scoreboard.
module tb_apb_master;
   import apb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic pclk = 1'b0;
   logic preset;

   always #5 pclk = ~pclk;

   apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   apb_master #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TO)
   ) dut (
      .pclk  (pclk),
      .preset(preset),
      .bus   (bus)
   );

   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];
   int          wait_n;
   int          acc_cnt = 0;
   logic        stuck;
   logic        err_flag;
   logic        pre_we;
   logic [3:0]  pre_idx;
   logic [31:0] pre_dat;

   always @(posedge pclk) begin
      if (bus.psel && bus.penable && !bus.pready)
         acc_cnt <= acc_cnt + 1;
      else
         acc_cnt <= 0;
      if (bus.psel && bus.penable && bus.pready && bus.pwrite)
         mem[bus.paddr[5:2]] <= bus.pwdata;
      if (pre_we)
         mem[pre_idx] <= pre_dat;
   end

   assign bus.pready  = !stuck && (acc_cnt >= wait_n);
   assign bus.prdata  = (bus.psel && bus.penable) ?
                        mem[bus.paddr[5:2]] : 32'h0;
   assign bus.pslverr = err_flag;

   rsp_t sb [$];
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h required 0x%0h",
                tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      @(negedge pclk);
      pre_we  = 1'b1;
      pre_idx = 4'(idx);
      pre_dat = d;
      ref_mem[idx] = d;
      @(negedge pclk);
      pre_we  = 1'b0;
   endtask

   task automatic issue(input logic wr,
                        input logic [31:0] a,
                        input logic [31:0] d);
      bit got;
      got = 1'b0;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      for (int i = 0; i < 10; i++) begin
         if (bus.cmd_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge pclk);
      end
      chk("accept", 64'(got), 64'd1);
      @(posedge pclk);
      #1;
      // scramble fields to show they are ignored after acceptance
      bus.cmd_valid = 1'b0;
      bus.cmd_write = ~wr;
      bus.cmd_addr  = 32'hBAD0_0BAD;
      bus.cmd_wdata = 32'h0BAD_F00D;
   endtask

   task automatic wait_rsp(input string tag, input int lat_e,
                           input int acc_e, input logic [31:0] a,
                           input logic wr, input logic [31:0] d);
      int   lat;
      int   sel_n;
      int   en_n;
      bit   seen;
      bit   stab;
      rsp_t e;
      lat   = 0;
      sel_n = 0;
      en_n  = 0;
      seen  = 1'b0;
      stab  = 1'b1;
      e     = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk);
         lat++;
         if (bus.psel) begin
            sel_n++;
            if (bus.paddr !== a || bus.pwrite !== wr ||
                bus.cmd_ready !== 1'b0 ||
                (wr && bus.pwdata !== d))
               stab = 1'b0;
         end
         if (bus.penable)
            en_n++;
         if (bus.rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_seen"}, 64'(seen), 64'd1);
      chk({tag, "_lat"}, 64'(lat), 64'(lat_e));
      chk({tag, "_psel_cyc"}, 64'(sel_n), 64'(acc_e + 1));
      chk({tag, "_pen_cyc"}, 64'(en_n), 64'(acc_e));
      chk({tag, "_stable"}, 64'(stab), 64'd1);
      chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0)
         e = sb.pop_front();
      chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
      chk({tag, "_err"}, 64'(bus.rsp_err), 64'(e.err));
      chk({tag, "_psel_off"}, 64'(bus.psel), 64'd0);
      @(negedge pclk);
      chk({tag, "_pulse"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_hold"}, 64'({bus.rsp_err, bus.rsp_rdata}),
          64'(e));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ba [3];
      logic [31:0] bd [3];
      logic        bw [3];
      int          acc_cyc [$];
      int          k;
      int          nrsp;
      int          psel_lo;
      bit          spur;
      rsp_t        e;

      preset        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      wait_n        = 0;
      stuck         = 1'b0;
      err_flag      = 1'b0;
      pre_we        = 1'b0;
      pre_idx       = '0;
      pre_dat       = '0;
      for (int i = 0; i < 16; i++)
         ref_mem[i] = 'x;

      preload(4, 32'h1234_5678);
      preload(8, 32'hA5A5_0001);
      preload(12, 32'hFFFF_0000);
      chk("rst_psel", 64'(bus.psel), 64'd0);
      chk("rst_penable", 64'(bus.penable), 64'd0);
      chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
      chk("rst_paddr", 64'(bus.paddr), 64'd0);
      chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      preset = 1'b0;
      #1;
      chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

      // read zero wait, preloaded word
      sb.push_back('{err: 1'b0, rdata: ref_mem[4]});
      issue(1'b0, 32'h10, 32'h0);
      wait_rsp("rd0", 3, 1, 32'h10, 1'b0, 32'h0);

      // write zero wait
      ref_mem[4] = 32'hDEAD_BEEF;
      sb.push_back('{err: 1'b0, rdata: 32'h0});
      issue(1'b1, 32'h10, 32'hDEAD_BEEF);
      wait_rsp("wr0", 3, 1, 32'h10, 1'b1, 32'hDEAD_BEEF);

      sb.push_back('{err: 1'b0, rdata: ref_mem[4]});
      issue(1'b0, 32'h10, 32'h0);
      wait_rsp("rd1", 3, 1, 32'h10, 1'b0, 32'h0);

      // three wait states with slave error
      wait_n   = 3;
      err_flag = 1'b1;
      sb.push_back('{err: 1'b1, rdata: ref_mem[8]});
      issue(1'b0, 32'h20, 32'h0);
      wait_rsp("wait3", 3 + 3, 4, 32'h20, 1'b0, 32'h0);
      wait_n   = 0;
      err_flag = 1'b0;

      // timeout: pready stuck low
      stuck = 1'b1;
      sb.push_back('{err: 1'b1, rdata: 32'h0});
      issue(1'b0, 32'h30, 32'h0);
      wait_rsp("tmo", 3 + TO, TO + 1, 32'h30, 1'b0, 32'h0);
      stuck = 1'b0;

      // back-to-back with cmd_valid held high
      bw[0] = 1'b1; ba[0] = 32'h18; bd[0] = 32'h1111_1111;
      bw[1] = 1'b1; ba[1] = 32'h1C; bd[1] = 32'h2222_2222;
      bw[2] = 1'b0; ba[2] = 32'h18; bd[2] = 32'h0;
      k       = 0;
      nrsp    = 0;
      psel_lo = 0;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = bw[0];
      bus.cmd_addr  = ba[0];
      bus.cmd_wdata = bd[0];
      for (int c = 0; c < 30 && nrsp < 3; c++) begin
         if (bus.rsp_valid) begin
            e = '0;
            if (sb.size() > 0)
               e = sb.pop_front();
            chk("b2b_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            chk("b2b_err", 64'(bus.rsp_err), 64'(e.err));
            nrsp++;
         end
         if (acc_cyc.size() > 0 && acc_cyc.size() < 3 && !bus.psel)
            psel_lo++;
         if (bus.cmd_valid && bus.cmd_ready) begin
            acc_cyc.push_back(c);
            if (bw[k]) begin
               ref_mem[ba[k][5:2]] = bd[k];
               sb.push_back('{err: 1'b0, rdata: 32'h0});
            end else begin
               sb.push_back('{err: 1'b0, rdata: ref_mem[ba[k][5:2]]});
            end
            @(posedge pclk);
            #1;
            k++;
            if (k < 3) begin
               bus.cmd_write = bw[k];
               bus.cmd_addr  = ba[k];
               bus.cmd_wdata = bd[k];
            end else begin
               bus.cmd_valid = 1'b0;
            end
         end
         @(negedge pclk);
      end
      chk("b2b_nrsp", 64'(nrsp), 64'd3);
      chk("b2b_nacc", 64'(acc_cyc.size()), 64'd3);
      if (acc_cyc.size() == 3) begin
         chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
         chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
      end
      chk("b2b_psel_low", 64'(psel_lo), 64'd2);

      // reset during ACCESS drops the transfer
      wait_n = 5;
      issue(1'b0, 32'h10, 32'h0);
      @(negedge pclk);
      @(negedge pclk);
      chk("mid_in_access", 64'(bus.penable), 64'd1);
      preset = 1'b1;
      @(negedge pclk);
      chk("mid_psel", 64'(bus.psel), 64'd0);
      chk("mid_penable", 64'(bus.penable), 64'd0);
      chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      preset = 1'b0;
      spur = 1'b0;
      repeat (8) begin
         @(negedge pclk);
         if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0)
            spur = 1'b1;
      end
      chk("mid_quiet", 64'(spur), 64'd0);
      wait_n = 0;
      sb.push_back('{err: 1'b0, rdata: ref_mem[4]});
      issue(1'b0, 32'h10, 32'h0);
      wait_rsp("post_rst", 3, 1, 32'h10, 1'b0, 32'h0);

      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
